// File: rtl/regbank_sb.sv
// Register bank with a per-register pending-write scoreboard and hazard stall.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle writeback forwarding.
`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module regbank_sb (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [`REG_ADDR-1:0] src_reg1,
  input  logic [`REG_ADDR-1:0] src_reg2,
  output logic [`REG_SIZE-1:0] rin_reg1,
  output logic [`REG_SIZE-1:0] rin_reg2,
  input  logic                 issue_valid,
  input  logic [`REG_ADDR-1:0] issue_dest,
  input  logic                 wb_regwrite,
  input  logic [`REG_ADDR-1:0] wb_dest,
  input  logic [`REG_SIZE-1:0] wb_data,
  output logic                 stall,
  output logic                 sb_error
);

  localparam int AW = `REG_ADDR;
  localparam int DW = `REG_SIZE;
  localparam int NR = 1 << AW;

  logic [DW-1:0] regs_q [NR];
  logic [1:0]    pend_q [NR];
  logic [1:0]    pend_d [NR];
  logic          err_q;
  logic          err_d;

  logic          wb_we;
  logic          issue_acc;
  logic          busy1;
  logic          busy2;
  logic          dest_full;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  // Register 0 is never written, so its storage stays at its reset value of 0.
  assign wb_we = wb_regwrite && (wb_dest != '0);
  assign rd1   = regs_q[src_reg1];
  assign rd2   = regs_q[src_reg2];

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // A writeback retiring the last pending write un-busies the source this cycle.
  assign byp1     = wb_we && (src_reg1 == wb_dest);
  assign byp2     = wb_we && (src_reg2 == wb_dest);
  assign busy1    = (src_reg1 != '0) && (pend_q[src_reg1] != 2'd0) &&
                    !(byp1 && (pend_q[src_reg1] == 2'd1));
  assign busy2    = (src_reg2 != '0) && (pend_q[src_reg2] != 2'd0) &&
                    !(byp2 && (pend_q[src_reg2] == 2'd1));
  assign rin_reg1 = byp1 ? wb_data : rd1;
  assign rin_reg2 = byp2 ? wb_data : rd2;
`else
  assign busy1    = (src_reg1 != '0) && (pend_q[src_reg1] != 2'd0);
  assign busy2    = (src_reg2 != '0) && (pend_q[src_reg2] != 2'd0);
  assign rin_reg1 = rd1;
  assign rin_reg2 = rd2;
`endif

  assign dest_full = issue_valid && (pend_q[issue_dest] == 2'd3);
  assign stall     = busy1 || busy2 || dest_full;
  assign issue_acc = issue_valid && !stall && (issue_dest != '0);

  // Issue and writeback to the same register cancel; saturation is guarded
  // by the stall, but the increment is still clamped at 3.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      pend_d[i] = pend_q[i];
      if (i != 0) begin
        if (issue_acc && (issue_dest == AW'(i)) && wb_we && (wb_dest == AW'(i))) begin
          pend_d[i] = pend_q[i];
        end else if (issue_acc && (issue_dest == AW'(i))) begin
          if (pend_q[i] != 2'd3) pend_d[i] = pend_q[i] + 2'd1;
        end else if (wb_we && (wb_dest == AW'(i)) && (pend_q[i] != 2'd0)) begin
          pend_d[i] = pend_q[i] - 2'd1;
        end
      end else begin
        pend_d[i] = 2'd0;
      end
    end
  end

  // Any writeback (register 0 included) without a pending write is an error.
  assign err_d    = err_q || (wb_regwrite && (pend_q[wb_dest] == 2'd0));
  assign sb_error = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) begin
        regs_q[i] <= '0;
        pend_q[i] <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      if (wb_we) regs_q[wb_dest] <= wb_data;
      for (int i = 0; i < NR; i++) begin
        pend_q[i] <= pend_d[i];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_regbank_sb.sv
// Self-checking bench for regbank_sb: directed vector table, reset corner case,
// and randomized traffic against a behavioural scoreboard model.
`ifndef REG_ADDR
`define REG_ADDR 5
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module tb_regbank_sb;

  localparam int AW = `REG_ADDR;
  localparam int DW = `REG_SIZE;
  localparam int NR = 1 << AW;
  localparam int W  = 2 + 2 * DW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          rst;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    bit          iv;
    logic [AW-1:0] idest;
    bit          wbw;
    logic [AW-1:0] wbd;
    logic [DW-1:0] wbdata;
    bit          e_stall;
    logic [DW-1:0] e_r1;
    logic [DW-1:0] e_r2;
    bit          e_err;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [AW-1:0] src_reg1;
  logic [AW-1:0] src_reg2;
  logic [DW-1:0] rin_reg1;
  logic [DW-1:0] rin_reg2;
  logic          issue_valid;
  logic [AW-1:0] issue_dest;
  logic          wb_regwrite;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          stall;
  logic          sb_error;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  // Behavioural model state
  logic [DW-1:0] m_reg  [NR];
  int            m_pend [NR];
  bit            m_err;

  regbank_sb dut (
    .clk         (clk),
    .reset       (reset),
    .src_reg1    (src_reg1),
    .src_reg2    (src_reg2),
    .rin_reg1    (rin_reg1),
    .rin_reg2    (rin_reg2),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .wb_regwrite (wb_regwrite),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .stall       (stall),
    .sb_error    (sb_error)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endfunction

  function automatic bit m_src_busy(input int a, input vec_t v);
    bit b;
    b = (a != 0) && (m_pend[a] > 0);
    if (BYP && v.wbw && (v.wbd != 0) && (int'(v.wbd) == a) && (m_pend[a] == 1)) b = 1'b0;
    return b;
  endfunction

  function automatic logic [DW-1:0] m_read(input int a, input vec_t v);
    if (BYP && v.wbw && (v.wbd != 0) && (int'(v.wbd) == a)) return v.wbdata;
    return (a == 0) ? '0 : m_reg[a];
  endfunction

  function automatic bit m_stall(input vec_t v);
    return m_src_busy(int'(v.src1), v) || m_src_busy(int'(v.src2), v) ||
           (v.iv && (m_pend[v.idest] == 3));
  endfunction

  function automatic void model_step(input vec_t v);
    bit acc;
    bit wbhit;
    acc   = v.iv && !m_stall(v) && (v.idest != 0);
    wbhit = v.wbw && (v.wbd != 0);
    if (v.wbw && (m_pend[v.wbd] == 0)) m_err = 1'b1;
    if (wbhit) m_reg[v.wbd] = v.wbdata;
    if (!(acc && wbhit && (v.idest == v.wbd))) begin
      if (acc) m_pend[v.idest] = m_pend[v.idest] + 1;
      if (wbhit && (m_pend[v.wbd] > 0)) m_pend[v.wbd] = m_pend[v.wbd] - 1;
    end
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    src_reg1    = v.src1;
    src_reg2    = v.src2;
    issue_valid = v.iv;
    issue_dest  = v.idest;
    wb_regwrite = v.wbw;
    wb_dest     = v.wbd;
    wb_data     = v.wbdata;
  endtask

  task automatic idle();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, '0, 0, '0, '0, 0);
    drive(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic vec_t mk(input bit rst, input int s1, input int s2, input bit iv,
                              input int id, input bit wbw, input int wd,
                              input logic [DW-1:0] wdat, input bit st,
                              input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                              input bit err);
    vec_t v;
    v.rst = rst;  v.src1 = AW'(s1); v.src2 = AW'(s2);
    v.iv = iv;    v.idest = AW'(id);
    v.wbw = wbw;  v.wbd = AW'(wd);  v.wbdata = wdat;
    v.e_stall = st; v.e_r1 = r1; v.e_r2 = r2; v.e_err = err;
    return v;
  endfunction

  // Applies one vector, compares against its recorded expectations, advances the model.
  task automatic apply_vec(input vec_t v, input int idx);
    if (v.rst) do_reset();
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d_stall", idx), DW'(stall),    DW'(v.e_stall));
    chk($sformatf("v%0d_rin1", idx),  rin_reg1,      v.e_r1);
    chk($sformatf("v%0d_rin2", idx),  rin_reg2,      v.e_r2);
    chk($sformatf("v%0d_err", idx),   DW'(sb_error), DW'(v.e_err));
    model_step(v);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    logic [W-1:0] e;
    logic [W-1:0] a;
    int nz[$];

    reset = 1'b1;
    idle();

    // Reads, register 0 protection, sb_error on writeback to 0
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, '0, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 5, 0, 0, 1, 0, 32'hDEADBEEF, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 5, 0, 0, 0, 0, '0, 0, '0, '0, 1));
    // Read-after-write hazard on register 7
    tbl.push_back(mk(1, 0, 0, 1, 7, 0, 0, '0, 0, '0, '0, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, '0, 1, '0, '0, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 1, 7, 32'h12345678, !BYP,
                     BYP ? 32'h12345678 : 32'h0, '0, 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 0, 0, '0, 0, 32'h12345678, '0, 0));
    // Saturation of pending[9] at 3 and drain back to 0
    tbl.push_back(mk(1, 0, 0, 1, 9, 0, 0, '0, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, '0, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, '0, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, '0, 1, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, '0, 1, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 32'h11, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 32'h22, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 9, 32'h33, 0, '0, '0, 0));
    tbl.push_back(mk(0, 9, 0, 0, 0, 0, 0, '0, 0, 32'h33, '0, 0));
    tbl.push_back(mk(0, 0, 9, 0, 0, 1, 9, 32'h44, 0, '0, 32'h33, 0));
    tbl.push_back(mk(0, 0, 9, 0, 0, 0, 0, '0, 0, '0, 32'h44, 1));
    // Simultaneous issue and writeback to register 4
    tbl.push_back(mk(1, 0, 0, 1, 4, 0, 0, '0, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4, 1, 4, 32'h44, 0, '0, '0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, '0, 1, '0, 32'h44, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 1, 4, 32'h55, !BYP, '0,
                     BYP ? 32'h55 : 32'h44, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, '0, 0, '0, 32'h55, 0));

    foreach (tbl[i]) apply_vec(tbl[i], i);

    // Reset asserted between edges clears pending work immediately
    apply_vec(mk(1, 0, 0, 1, 3, 0, 0, '0, 0, '0, '0, 0), 100);
    @(negedge clk);
    v = mk(0, 3, 3, 1, 3, 0, 0, '0, 0, '0, '0, 0);
    drive(v);
    #1;
    chk("pre_rst_stall", DW'(stall), DW'(1'b1));
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("in_rst_stall", DW'(stall),    DW'(1'b0));
    chk("in_rst_err",   DW'(sb_error), DW'(1'b0));
    @(posedge clk);
    #1 reset = 1'b1;
    apply_vec(mk(0, 0, 0, 0, 0, 1, 3, 32'h77, 0, '0, '0, 0), 101);
    apply_vec(mk(0, 3, 0, 0, 0, 0, 0, '0, 0, 32'h77, '0, 1), 102);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      v.rst    = ($urandom_range(0, 199) == 0);
      v.src1   = AW'($urandom_range(0, 7));
      v.src2   = AW'($urandom_range(0, 7));
      v.iv     = ($urandom_range(0, 1) == 1);
      v.idest  = AW'($urandom_range(0, 7));
      v.wbw    = ($urandom_range(0, 2) != 0);
      v.wbdata = DW'($urandom);
      nz.delete();
      for (int r = 1; r < 8; r++) if (m_pend[r] > 0) nz.push_back(r);
      if (nz.size() > 0 && $urandom_range(0, 19) != 0)
        v.wbd = AW'(nz[$urandom_range(0, nz.size() - 1)]);
      else
        v.wbd = AW'($urandom_range(0, 7));
      if (v.rst) do_reset();
      @(negedge clk);
      drive(v);
      exp_q.push_back({m_stall(v), m_err, m_read(int'(v.src1), v), m_read(int'(v.src2), v)});
      #1;
      a = {stall, sb_error, rin_reg1, rin_reg2};
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL rnd%0d {stall,err,rin1,rin2} actual=%h required=%h", n, a, e);
      end
      model_step(v);
    end

    @(negedge clk);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regbank_sb.md
REGBANK_SB -- requirements
Module: regbank_sb

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 src_reg1  input  `REG_ADDR  read address, port 1, driven by decode.
REQ-005 src_reg2  input  `REG_ADDR  read address, port 2, driven by decode.
REQ-006 rin_reg1  output  `REG_SIZE  read data, port 1, returned to decode.
REQ-007 rin_reg2  output  `REG_SIZE  read data, port 2, returned to decode.
REQ-008 issue_valid  input  1  decode issues an instruction with regwrite=1 this cycle.
REQ-009 issue_dest  input  `REG_ADDR  destination register of the issuing instruction.
REQ-010 wb_regwrite  input  1  writeback stage writes a register this cycle.
REQ-011 wb_dest  input  `REG_ADDR  writeback destination register.
REQ-012 wb_data  input  `REG_SIZE  writeback data.
REQ-013 stall  output  1  decode must hold; issue not accepted this cycle.
REQ-014 sb_error  output  1  sticky flag: writeback to a register with no pending write.

Function
REQ-015 Storage: 2^`REG_ADDR registers of `REG_SIZE bits; register 0 reads 0; writes to register 0 discarded.
REQ-016 Reads: combinational, zero latency, rin_regN = reg[src_regN].
REQ-017 Write: on rising clk when wb_regwrite=1 and wb_dest!=0, reg[wb_dest] <= wb_data.
REQ-018 Scoreboard: one 2-bit pending counter per register (0..3); register 0 counter fixed at 0.
REQ-019 Issue accepted = issue_valid & ~stall & issue_dest!=0; accepted issue increments pending[issue_dest].
REQ-020 Writeback with wb_regwrite=1, wb_dest!=0 and pending[wb_dest]>0 decrements pending[wb_dest].
REQ-021 Accepted issue and writeback to the same register in the same cycle: counter unchanged.
REQ-022 Writeback when pending[wb_dest]=0: data still written, counter stays 0, sb_error set to 1 next edge and held until reset.
REQ-023 stall=1 if src_reg1 is busy, or src_reg2 is busy, or (issue_valid=1 and pending[issue_dest]=3).
REQ-024 A source is busy when its address !=0 and pending[addr]!=0, except as relaxed by REQ-029.
REQ-025 stall is combinational from current state and inputs; no stall for address 0 ever.
REQ-026 Saturation: pending never wraps 3->0; issue to a register at 3 is stalled, not counted.

Reset
REQ-027 reset=0 asynchronously clears all registers to 0, all pending counters to 0, and sb_error to 0; stall is therefore 0 while in reset regardless of inputs.
REQ-028 Reset mid-operation discards all outstanding pending counts; later writebacks to those registers set sb_error.

Configuration
REQ-029 With REGFILE_BYPASS_EN defined: when wb_regwrite=1, wb_dest!=0 and src_regN=wb_dest, rin_regN=wb_data in the same cycle, and the source counts as not busy if pending[wb_dest]=1.
REQ-030 Without REGFILE_BYPASS_EN: rin_regN returns the stored value (old data) and the source is busy until pending reaches 0 one cycle after writeback.

Verification
REQ-031 Reset, then read src_reg1=5, src_reg2=0 -> rin_reg1=0, rin_reg2=0, stall=0, sb_error=0.
REQ-032 wb_regwrite=1, wb_dest=0, wb_data=0xDEADBEEF, then read src_reg1=0 -> rin_reg1=0, sb_error=1, no register modified.
REQ-033 Issue dest=7; next cycle src_reg1=7 -> stall=1; wb_dest=7, wb_data=0x12345678 that cycle -> with REGFILE_BYPASS_EN stall=0, rin_reg1=0x12345678 same cycle; without it stall=1 that cycle, stall=0 and rin_reg1=0x12345678 the following cycle.
REQ-034 Three accepted issues to dest=9, fourth issue_valid with issue_dest=9 -> stall=1, pending[9] stays 3; three writebacks to 9 -> pending[9]=0, sb_error=0.
REQ-035 Same cycle: issue dest=4 accepted and writeback wb_dest=4 with pending[4]=1 -> pending[4] remains 1, src_reg2=4 next cycle -> stall=1.
REQ-036 Issue dest=3, assert reset=0 mid-cycle (between edges) -> pending cleared immediately, stall=0; after release, writeback to 3 -> sb_error=1.
